mul_long_unit: RTL and testbench
================================

Name: mul_long_unit

Overview:
Iterative shift-add multiplier feeding the register-file write ports. It supports MUL (32-bit result), UMULL and SMULL (64-bit RdHi:RdLo).
- Consumes register-read operands; produces lo/hi results plus destination addresses and write enables that drive the two regfile write ports.
- Asserts busy so the control unit stalls the PC until the result is written.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH; iteration count = WIDTH.
CNT_W, 5, counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  00 MUL, 01 UMULL, 10 SMULL, 11 treated as UMULL
a  in  WIDTH  operand Rm (from rd1)
b  in  WIDTH  operand Rs (from rd2)
rd_lo  in  4  destination for low word (RdLo, or Rd for MUL)
rd_hi  in  4  destination for high word (RdHi)
busy  out  1  high in CALC and FIX
done  out  1  one-cycle pulse in DONE
res_lo  out  WIDTH  product bits [WIDTH-1:0]
res_hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]
wa_lo  out  4  latched rd_lo
wa_hi  out  4  latched rd_hi
we_lo  out  1  = done
we_hi  out  1  = done and op_latched != MUL

Behaviour:
Reset state and values:
- Reset forces IDLE.
- Clears res_lo, res_hi, wa_lo, wa_hi, the counter and the internal accumulator.
- busy=0, done=0, we_lo=0, we_hi=0.
- Reset mid-operation aborts: no done pulse and no write enable follows.

States and transitions (IDLE, CALC, FIX, DONE):
- IDLE: on start=1 at edge E0, latch op, rd_lo and rd_hi. Load the multiplicand and multiplier:
  - SMULL: two's-complement absolute values of a and b; record neg = a[MSB] xor b[MSB].
  - Otherwise: a and b unchanged, neg = 0.
  - Clear the accumulator and counter. Go to CALC.
- CALC: one iteration per edge. If multiplier LSB = 1, add the multiplicand into the accumulator upper half with carry. Then shift the {carry, accumulator} right by 1 and shift the multiplier right by 1. Counter increments. After the iteration with counter = WIDTH-1, go to FIX.
- FIX: if neg, res = two's-complement negation of the 2*WIDTH accumulator; else res = accumulator. Register res_lo/res_hi. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.

Latency and timing:
- Fixed regardless of operand values (zero operands do not short-circuit).
- Edges E1..E(WIDTH) iterate, E(WIDTH+1) is FIX, and done is high in the cycle after E(WIDTH+1).
- For WIDTH=32: start at E0, done high after E33, back to IDLE at E34.

Handshake:
- start is ignored in CALC, FIX and DONE; no queueing. A start held high in IDLE launches exactly one operation.
- a, b, op, rd_* may change after E0 without effect.
- Control stalls while busy=1; the regfile write occurs at the edge that ends the DONE cycle.

Result rules:
- res_lo, res_hi, wa_lo and wa_hi hold their values after DONE until the next FIX/start.
- MUL still computes the full product but enables only we_lo.
- SMULL with a = 0x80000000: its absolute value 0x80000000 is used unsigned, which gives the correct result.

Decomposition:
- Shared package (mul_pkg): op encodings OP_MUL / OP_UMULL / OP_SMULL, state encoding for IDLE/CALC/FIX/DONE, and the WIDTH default.
- One natural sub-module, mul_sign_fix: combinational conditional 2*WIDTH negation, also reused for abs on operand load.
- Controller and shift-add datapath stay in mul_long_unit.

Test Plan:
1. MUL: a=7, b=6, rd_lo=3 -> done exactly 33 edges after start edge; res_lo=42, wa_lo=3, we_lo=1, we_hi=0, busy=1 for 33 cycles.
2. UMULL: a=b=0xFFFFFFFF -> res_hi=0xFFFFFFFE, res_lo=0x00000001, we_lo=we_hi=1.
3. SMULL: a=0xFFFFFFFD(-3), b=5 -> res_hi=0xFFFFFFFF, res_lo=0xFFFFFFF1. Also a=b=0x80000000 -> res_hi=0x40000000, res_lo=0.
4. Reset mid-op: assert reset 10 cycles after start -> next cycle busy=0, and no done/we for 40 cycles. A new start then yields a correct result with full latency.
5. start pulsed in CALC with different operands -> ignored; the original result is produced, and busy drops exactly once.
6. Back-to-back: start held high continuously -> a second operation launches from IDLE at E34; each operation produces exactly one done pulse.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared definitions for the iterative long multiplier:
//                operation encodings, controller state encoding and the
//                default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Default operand width; the full product is twice this.
    localparam int MUL_WIDTH = 32;

    // Operation encodings as presented on op_i. Encoding 2'b11 has no name
    // of its own and behaves exactly like UMULL.
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // SMULL is the only signed operation; every other encoding is unsigned.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_SMULL);
    endfunction

    // MUL keeps only the low word; everything else writes RdHi as well.
    function automatic logic op_writes_hi(input logic [1:0] op);
        return (op != OP_MUL);
    endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sign_fix
//  Description : Combinational conditional two's-complement negation.
//                Used for the absolute value of signed operands at load time
//                and for restoring the sign of the final product.
//  Ports       : in_i   [W-1:0]  value to condition
//                neg_i           1 = negate, 0 = pass through
//                out_o  [W-1:0]  neg_i ? -in_i : in_i
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i,
    input  logic         neg_i,
    output logic [W-1:0] out_o
);

    // -x == ~x + 1. The most negative value maps onto itself, which is
    // exactly what the unsigned core needs for the 0x8000... operand.
    always_comb begin
        out_o = in_i;
        if (neg_i) begin
            out_o = (~in_i) + W'(1);
        end
    end

endmodule : mul_sign_fix
`default_nettype wire

// File: rtl/mul_long_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_long_unit
//  Description : Iterative shift-add multiplier that drives the two register
//                file write ports. Supports MUL (low word only), UMULL and
//                SMULL (RdHi:RdLo). One product bit per cycle, fixed latency.
//  Ports       : clk_i               rising-edge clock
//                reset_i             synchronous active-high reset
//                start_i             request, sampled only while idle
//                op_i      [1:0]     00 MUL, 01 UMULL, 10 SMULL, 11 = UMULL
//                a_i/b_i   [W-1:0]   operands Rm / Rs
//                rd_lo_i/rd_hi_i     destination registers
//                busy_o              high while calculating and fixing sign
//                done_o              single-cycle completion pulse
//                res_lo_o/res_hi_o   product low / high words
//                wa_lo_o/wa_hi_o     latched destination registers
//                we_lo_o/we_hi_o     write enables for the two ports
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_long_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       rd_lo_i,
    input  logic [3:0]       rd_hi_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [3:0]       wa_lo_o,
    output logic [3:0]       wa_hi_o,
    output logic             we_lo_o,
    output logic             we_hi_o
);

    // Value of the counter during the final iteration.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [1:0]           op_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 we_lo_q;
    logic                 we_hi_q;
    logic [WIDTH-1:0]     res_lo_q;
    logic [WIDTH-1:0]     res_hi_q;
    logic [3:0]           wa_lo_q;
    logic [3:0]           wa_hi_q;

    // ------------------------------------------------------------------
    // Operand conditioning at load time
    // ------------------------------------------------------------------
    logic                 w_load_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;

    assign w_load_signed = op_is_signed(op_i);
    assign w_a_neg       = w_load_signed & a_i[WIDTH-1];
    assign w_b_neg       = w_load_signed & b_i[WIDTH-1];

    mul_sign_fix #(
        .W (WIDTH)
    ) u_abs_a (
        .in_i  (a_i),
        .neg_i (w_a_neg),
        .out_o (w_a_abs)
    );

    mul_sign_fix #(
        .W (WIDTH)
    ) u_abs_b (
        .in_i  (b_i),
        .neg_i (w_b_neg),
        .out_o (w_b_abs)
    );

    // ------------------------------------------------------------------
    // One shift-add iteration
    // ------------------------------------------------------------------
    // The multiplicand is added into the upper half only; the carry out of
    // that add becomes the new MSB once the whole accumulator shifts right.
    // After WIDTH iterations the accumulator holds the unsigned product.
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_upper;
    logic [2*WIDTH-1:0]   acc_d;

    assign w_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign w_upper = mplier_q[0] ? w_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign acc_d   = {w_upper, acc_q[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Sign restoration of the final product
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   w_res_fix;

    mul_sign_fix #(
        .W (2 * WIDTH)
    ) u_res_fix (
        .in_i  (acc_q),
        .neg_i (neg_q),
        .out_o (w_res_fix)
    );

    // ------------------------------------------------------------------
    // Controller and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_lo_q  <= 1'b0;
            we_hi_q  <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            wa_lo_q  <= '0;
            wa_hi_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q     <= op_i;
                        wa_lo_q  <= rd_lo_i;
                        wa_hi_q  <= rd_hi_i;
                        mcand_q  <= w_a_abs;
                        mplier_q <= w_b_abs;
                        neg_q    <= w_load_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    // No early exit on a zero multiplier: latency is fixed.
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == c_CNT_LAST) begin
                        state_q <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    res_lo_q <= w_res_fix[WIDTH-1:0];
                    res_hi_q <= w_res_fix[2*WIDTH-1:WIDTH];
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    we_lo_q  <= 1'b1;
                    we_hi_q  <= op_writes_hi(op_q);
                    state_q  <= ST_DONE;
                end

                ST_DONE: begin
                    // The register file captures the write at this edge.
                    done_q  <= 1'b0;
                    we_lo_q <= 1'b0;
                    we_hi_q <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign we_lo_o  = we_lo_q;
    assign we_hi_o  = we_hi_q;
    assign res_lo_o = res_lo_q;
    assign res_hi_o = res_hi_q;
    assign wa_lo_o  = wa_lo_q;
    assign wa_hi_o  = wa_hi_q;

endmodule : mul_long_unit
`default_nettype wire

// File: tb/tb_mul_long_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_long_unit
//  Description : Self-checking bench for mul_long_unit. A cycle-level model
//                derives every output from the operation rules with plain
//                arithmetic; directed scenarios add hand-computed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_long_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    rd_lo;
    logic [3:0]    rd_hi;
    logic          busy;
    logic          done;
    logic [W-1:0]  res_lo;
    logic [W-1:0]  res_hi;
    logic [3:0]    wa_lo;
    logic [3:0]    wa_hi;
    logic          we_lo;
    logic          we_hi;

    always #5 clk = ~clk;

    mul_long_unit #(
        .WIDTH (W),
        .CNT_W (5)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .rd_lo_i  (rd_lo),
        .rd_hi_i  (rd_hi),
        .busy_o   (busy),
        .done_o   (done),
        .res_lo_o (res_lo),
        .res_hi_o (res_hi),
        .wa_lo_o  (wa_lo),
        .wa_hi_o  (wa_hi),
        .we_lo_o  (we_lo),
        .we_hi_o  (we_hi)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product from the arithmetic definition of each operation.
    function automatic logic [63:0] ref_product(input logic [1:0] o,
                                                input logic [31:0] x,
                                                input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (o == 2'b10) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // ------------------------------------------------------------------
    // Model: m_phase counts edges since the accepting edge (-1 = idle).
    // Busy after edges 0..32, done after edge 33, idle after edge 34.
    // ------------------------------------------------------------------
    int          m_phase = -1;
    logic [1:0]  m_op    = 2'b00;
    logic [63:0] m_prod  = '0;
    logic [63:0] m_res   = '0;
    logic [3:0]  m_wa_lo = '0;
    logic [3:0]  m_wa_hi = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = -1;
            m_op    = 2'b00;
            m_res   = '0;
            m_wa_lo = '0;
            m_wa_hi = '0;
        end else if (m_phase < 0) begin
            if (start) begin
                m_phase = 0;
                m_op    = op;
                m_prod  = ref_product(op, a, b);
                m_wa_lo = rd_lo;
                m_wa_hi = rd_hi;
            end
        end else if (m_phase == 33) begin
            m_phase = -1;
        end else begin
            m_phase++;
            if (m_phase == 33) m_res = m_prod;
        end
        #1;
        chk("busy",   64'(busy),   64'(m_phase >= 0 && m_phase <= 32));
        chk("done",   64'(done),   64'(m_phase == 33));
        chk("we_lo",  64'(we_lo),  64'(m_phase == 33));
        chk("we_hi",  64'(we_hi),  64'(m_phase == 33 && m_op != 2'b00));
        chk("res",    {res_hi, res_lo}, m_res);
        chk("wa_lo",  64'(wa_lo),  64'(m_wa_lo));
        chk("wa_hi",  64'(wa_hi),  64'(m_wa_hi));
    end

    // Present a request for one cycle; returns at the negedge after E0.
    task automatic op_go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] lo, input logic [3:0] hi);
        repeat (2) @(negedge clk);
        op = o; a = x; b = y; rd_lo = lo; rd_hi = hi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = 2'b11; rd_lo = 4'hF; rd_hi = 4'hE;
    endtask

    // Bounded wait for done; edges counted from the current point.
    task automatic wait_done(output int edges, output int bcnt);
        edges = 0;
        bcnt  = busy ? 1 : 0;
        while (edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (done) break;
            if (busy) bcnt++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] lo, input logic [3:0] hi,
                          input logic [63:0] exp_prod, input logic exp_we_hi);
        int e, bc;
        op_go(o, x, y, lo, hi);
        wait_done(e, bc);
        chk({name, " latency"}, 64'(e), 64'd33);
        chk({name, " busy cycles"}, 64'(bc), 64'd33);
        chk({name, " product"}, {res_hi, res_lo}, exp_prod);
        chk({name, " wa_lo"}, 64'(wa_lo), 64'(lo));
        chk({name, " wa_hi"}, 64'(wa_hi), 64'(hi));
        chk({name, " we_lo"}, 64'(we_lo), 64'd1);
        chk({name, " we_hi"}, 64'(we_hi), 64'(exp_we_hi));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, bc, nd, d1, d2, bad;
        logic [63:0] r2;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; rd_lo = '0; rd_hi = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset res", {res_hi, res_lo}, 64'd0);

        // Basic operations with hand-computed products.
        run_op("T1 MUL 7x6", 2'b00, 32'd7, 32'd6, 4'd3, 4'd9, 64'd42, 1'b0);
        run_op("T2 UMULL max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 4'd2,
               64'hFFFF_FFFE_0000_0001, 1'b1);
        run_op("T3 SMULL -3x5", 2'b10, 32'hFFFF_FFFD, 32'd5, 4'd4, 4'd5,
               64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        run_op("T3 SMULL min^2", 2'b10, 32'h8000_0000, 32'h8000_0000, 4'd6, 4'd7,
               64'h4000_0000_0000_0000, 1'b1);
        run_op("MUL wide", 2'b00, 32'h1234_5678, 32'h10, 4'd8, 4'd10,
               64'h1_2345_6780, 1'b0);
        run_op("op11 unsigned", 2'b11, 32'h8000_0000, 32'd4, 4'd11, 4'd12,
               64'h2_0000_0000, 1'b1);
        run_op("SMULL -1x-1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd13, 4'd14, 64'd1, 1'b1);
        run_op("zero", 2'b01, 32'd0, 32'h1234_5678, 4'd0, 4'd15, 64'd0, 1'b1);

        // T4: reset ten cycles after start aborts the operation.
        op_go(2'b01, 32'h1234, 32'h5678, 4'd2, 4'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("T4 busy after reset", 64'(busy), 64'd0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || we_lo || we_hi) bad++;
        end
        chk("T4 no done after abort", 64'(bad), 64'd0);
        run_op("T4 restart", 2'b10, 32'd100, 32'hFFFF_FF9C, 4'd5, 4'd6,
               64'hFFFF_FFFF_FFFF_D8F0, 1'b1);

        // T5: start pulsed mid-calculation with other operands is ignored.
        op_go(2'b10, 32'hFFFF_FFF9, 32'd9, 4'd7, 4'd8);
        repeat (4) @(negedge clk);
        op = 2'b00; a = 32'd2; b = 32'd3; rd_lo = 4'd1; rd_hi = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(e, bc);
        chk("T5 remaining latency", 64'(e), 64'd28);
        chk("T5 busy cycles", 64'(bc), 64'd28);
        chk("T5 product", {res_hi, res_lo}, 64'hFFFF_FFFF_FFFF_FFC1);
        chk("T5 wa_lo", 64'(wa_lo), 64'd7);

        // T6: start held high launches back-to-back operations.
        repeat (2) @(negedge clk);
        op = 2'b01; a = 32'd3; b = 32'd5; rd_lo = 4'd9; rd_hi = 4'd10;
        start = 1'b1;
        nd = 0; d1 = -1; d2 = -1; r2 = '0;
        for (int i = 0; i < 75; i++) begin
            @(posedge clk); #1;
            if (i == 10) begin a = 32'd11; b = 32'd13; end
            if (done) begin
                nd++;
                if (nd == 1) d1 = i;
                if (nd == 2) begin d2 = i; r2 = {res_hi, res_lo}; end
            end
        end
        chk("T6 done count", 64'(nd), 64'd2);
        chk("T6 first done edge", 64'(d1), 64'd33);
        chk("T6 second done edge", 64'(d2), 64'd68);
        chk("T6 second product", r2, 64'd143);
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("T6 idle at end", 64'(busy), 64'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mul_long_unit
`default_nettype wire
